// File: rtl/elementwise_addr_sequencer.sv
// Walks an FP16 tensor (channel slice / row / column bursts) and issues lockstep A-read, B-read, O-write requests.
// Addresses come from running surface/line/column pointers per stream; each stream handshakes independently.
module elementwise_addr_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int DIM_W     = 16,
  parameter int LEN_W     = 8,
  parameter int PIX_BYTES = 64,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_c,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_o_base,
  input  logic [ADDR_W-1:0] cfg_in_surf,
  input  logic [ADDR_W-1:0] cfg_in_line,
  input  logic [ADDR_W-1:0] cfg_out_surf,
  input  logic [ADDR_W-1:0] cfg_out_line,
  input  logic              cfg_b_bcast,
  output logic              a_req_valid,
  input  logic              a_req_ready,
  output logic [ADDR_W-1:0] a_req_addr,
  output logic [LEN_W-1:0]  a_req_len,
  output logic              b_req_valid,
  input  logic              b_req_ready,
  output logic [ADDR_W-1:0] b_req_addr,
  output logic [LEN_W-1:0]  b_req_len,
  output logic              o_req_valid,
  input  logic              o_req_ready,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [LEN_W-1:0]  o_req_len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(MAX_BURST * PIX_BYTES);
  localparam logic [DIM_W-1:0]  MAX_N    = DIM_W'(MAX_BURST);
  localparam logic [DIM_W-1:0]  ONE      = DIM_W'(1);

  state_t r_state, w_state_nxt;

  logic [DIM_W-1:0]  r_h, r_w, r_c, r_hi, r_wi, r_ci;
  logic [ADDR_W-1:0] r_in_surf, r_in_line, r_out_surf, r_out_line;
  logic              r_bcast;
  logic [ADDR_W-1:0] r_a_surf, r_a_line, r_a_col;
  logic [ADDR_W-1:0] r_b_surf, r_b_line, r_b_col;
  logic [ADDR_W-1:0] r_o_surf, r_o_line, r_o_col;
  logic [LEN_W-1:0]  r_len;
  logic              r_a_acc, r_b_acc, r_o_acc;
  logic [31:0]       r_perf;

  function automatic logic [DIM_W-1:0] burst_n(input logic [DIM_W-1:0] rem);
    return (rem > MAX_N) ? MAX_N : rem;
  endfunction

  logic [DIM_W-1:0] w_n, w_wi_nxt;
  logic w_last_w, w_last_h, w_last_c, w_last_triple;
  logic w_a_hs, w_b_hs, w_o_hs, w_triple_done, w_start_ok, w_dims_ok;

  assign w_n           = burst_n(r_w - r_wi);
  assign w_wi_nxt      = r_wi + w_n;
  assign w_last_w      = (w_wi_nxt == r_w);
  assign w_last_h      = ((r_hi + ONE) == r_h);
  assign w_last_c      = ((r_ci + ONE) == r_c);
  assign w_last_triple = w_last_w & w_last_h & w_last_c;
  assign w_a_hs        = a_req_valid & a_req_ready;
  assign w_b_hs        = b_req_valid & b_req_ready;
  assign w_o_hs        = o_req_valid & o_req_ready;
  // A triple closes on the cycle its last outstanding handshake lands.
  assign w_triple_done = (r_a_acc | w_a_hs) & (r_b_acc | w_b_hs) & (r_o_acc | w_o_hs);
  assign w_start_ok    = (r_state == S_IDLE) & start;
  assign w_dims_ok     = (|cfg_h) & (|cfg_w) & (|cfg_c);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    o_req_valid = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_dims_ok ? S_ISSUE : S_DONE;
      S_ISSUE: begin
        a_req_valid = ~r_a_acc;
        b_req_valid = ~r_b_acc;
        o_req_valid = ~r_o_acc;
        if (w_triple_done && w_last_triple) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= '0; r_w <= '0; r_c <= '0; r_hi <= '0; r_wi <= '0; r_ci <= '0;
      r_in_surf <= '0; r_in_line <= '0; r_out_surf <= '0; r_out_line <= '0;
      r_bcast <= 1'b0;
      r_a_surf <= '0; r_a_line <= '0; r_a_col <= '0;
      r_b_surf <= '0; r_b_line <= '0; r_b_col <= '0;
      r_o_surf <= '0; r_o_line <= '0; r_o_col <= '0;
      r_len <= '0;
      r_a_acc <= 1'b0; r_b_acc <= 1'b0; r_o_acc <= 1'b0;
      r_perf <= '0;
    end else if (w_start_ok) begin
      r_h <= cfg_h; r_w <= cfg_w; r_c <= cfg_c;
      r_hi <= '0; r_wi <= '0; r_ci <= '0;
      r_in_surf <= cfg_in_surf; r_in_line <= cfg_in_line;
      r_out_surf <= cfg_out_surf; r_out_line <= cfg_out_line;
      r_bcast <= cfg_b_bcast;
      r_a_surf <= cfg_a_base; r_a_line <= cfg_a_base; r_a_col <= cfg_a_base;
      r_b_surf <= cfg_b_base; r_b_line <= cfg_b_base; r_b_col <= cfg_b_base;
      r_o_surf <= cfg_o_base; r_o_line <= cfg_o_base; r_o_col <= cfg_o_base;
      r_len <= LEN_W'(burst_n(cfg_w) - ONE);
      r_a_acc <= 1'b0; r_b_acc <= 1'b0; r_o_acc <= 1'b0;
      r_perf <= '0;
    end else begin
      if (r_state != S_IDLE) r_perf <= r_perf + 32'd1;
      if (r_state == S_ISSUE) begin
        if (w_triple_done) begin
          r_a_acc <= 1'b0; r_b_acc <= 1'b0; r_o_acc <= 1'b0;
          if (!w_last_triple) begin
            if (!w_last_w) begin
              // Only the row's final burst can be short, so non-final steps are a fixed stride.
              r_wi    <= w_wi_nxt;
              r_a_col <= r_a_col + COL_STEP;
              r_b_col <= r_b_col + COL_STEP;
              r_o_col <= r_o_col + COL_STEP;
              r_len   <= LEN_W'(burst_n(r_w - w_wi_nxt) - ONE);
            end else begin
              r_wi  <= '0;
              r_len <= LEN_W'(burst_n(r_w) - ONE);
              if (!w_last_h) begin
                r_hi     <= r_hi + ONE;
                r_a_line <= r_a_line + r_in_line;  r_a_col <= r_a_line + r_in_line;
                r_b_line <= r_b_line + r_in_line;  r_b_col <= r_b_line + r_in_line;
                r_o_line <= r_o_line + r_out_line; r_o_col <= r_o_line + r_out_line;
              end else begin
                r_hi     <= '0;
                r_ci     <= r_ci + ONE;
                r_a_surf <= r_a_surf + r_in_surf;  r_a_line <= r_a_surf + r_in_surf;
                r_a_col  <= r_a_surf + r_in_surf;
                r_b_surf <= r_b_surf + r_in_surf;  r_b_line <= r_b_surf + r_in_surf;
                r_b_col  <= r_b_surf + r_in_surf;
                r_o_surf <= r_o_surf + r_out_surf; r_o_line <= r_o_surf + r_out_surf;
                r_o_col  <= r_o_surf + r_out_surf;
              end
            end
          end
        end else begin
          r_a_acc <= r_a_acc | w_a_hs;
          r_b_acc <= r_b_acc | w_b_hs;
          r_o_acc <= r_o_acc | w_o_hs;
        end
      end
    end
  end

  assign a_req_addr  = r_a_col;
  assign a_req_len   = r_len;
  assign b_req_addr  = r_bcast ? r_b_surf : r_b_col;
  assign b_req_len   = r_bcast ? '0 : r_len;
  assign o_req_addr  = r_o_col;
  assign o_req_len   = r_len;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign perf_cycles = r_perf;

endmodule

// File: tb/tb_elementwise_addr_sequencer.sv
// Bench for elementwise_addr_sequencer: table of jobs, hand-written corner sequences, random jobs vs a loop-nest model.
module tb_elementwise_addr_sequencer;
  localparam int ADDR_W = 32, DIM_W = 16, LEN_W = 8, PIX = 64, MB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, cfg_b_bcast;
  logic [DIM_W-1:0] cfg_h, cfg_w, cfg_c;
  logic [ADDR_W-1:0] cfg_a_base, cfg_b_base, cfg_o_base, cfg_in_surf, cfg_in_line, cfg_out_surf, cfg_out_line;
  logic a_req_valid, a_req_ready, b_req_valid, b_req_ready, o_req_valid, o_req_ready;
  logic [ADDR_W-1:0] a_req_addr, b_req_addr, o_req_addr;
  logic [LEN_W-1:0] a_req_len, b_req_len, o_req_len;
  logic busy, done;
  logic [31:0] perf_cycles;

  elementwise_addr_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .LEN_W(LEN_W), .PIX_BYTES(PIX), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_c(cfg_c),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_o_base(cfg_o_base),
    .cfg_in_surf(cfg_in_surf), .cfg_in_line(cfg_in_line),
    .cfg_out_surf(cfg_out_surf), .cfg_out_line(cfg_out_line), .cfg_b_bcast(cfg_b_bcast),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr), .a_req_len(a_req_len),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr), .b_req_len(b_req_len),
    .o_req_valid(o_req_valid), .o_req_ready(o_req_ready), .o_req_addr(o_req_addr), .o_req_len(o_req_len),
    .busy(busy), .done(done), .perf_cycles(perf_cycles)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } req_t;
  typedef struct { int h; int w; int c; bit bc; int n_tri; int perf; logic [31:0] last_o; } vec_t;

  req_t q[3][$];
  string nm[3] = '{"a", "b", "o"};
  int errors = 0, checks = 0, cyc = 0, start_cyc = 0, done_cnt = 0, model_tri = 0, lat = 0;
  int hs_cnt[3];
  bit stall[3];
  logic [31:0] hold_addr[3];
  logic [7:0] hold_len[3];
  logic [31:0] last_o_addr;
  bit rand_rdy = 1'b0;
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Observes one cycle: handshakes are scored against the model, stalled requests must hold.
  task automatic sample();
    logic v[3], r[3];
    logic [31:0] ad[3];
    logic [7:0] ln[3];
    req_t e;
    v  = '{a_req_valid, b_req_valid, o_req_valid};
    r  = '{a_req_ready, b_req_ready, o_req_ready};
    ad = '{a_req_addr, b_req_addr, o_req_addr};
    ln = '{a_req_len, b_req_len, o_req_len};
    for (int i = 0; i < 3; i++) begin
      if (stall[i]) begin
        check({nm[i], "_hold_valid"}, 64'(v[i]), 64'd1);
        check({nm[i], "_hold_addr"}, 64'(ad[i]), 64'(hold_addr[i]));
        check({nm[i], "_hold_len"}, 64'(ln[i]), 64'(hold_len[i]));
      end
      stall[i] = v[i] && !r[i];
      hold_addr[i] = ad[i];
      hold_len[i] = ln[i];
      if (v[i] && r[i]) begin
        hs_cnt[i]++;
        if (q[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_extra: got request at 0x%0h, want none", nm[i], ad[i]);
        end else begin
          e = q[i].pop_front();
          check({nm[i], "_addr"}, 64'(ad[i]), 64'(e.addr));
          check({nm[i], "_len"}, 64'(ln[i]), 64'(e.len));
        end
      end
    end
    if (o_req_valid && o_req_ready) last_o_addr = o_req_addr;
    if (done) done_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_rdy) begin
      a_req_ready = ($urandom_range(0, 3) != 0);
      b_req_ready = ($urandom_range(0, 3) != 0);
      o_req_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic default_cfg();
    cfg_a_base = 32'h0; cfg_b_base = 32'h0100_0000; cfg_o_base = 32'h0800_0000;
    cfg_in_line = 32'h1000; cfg_in_surf = 32'h5000;
    cfg_out_line = 32'h0C00; cfg_out_surf = 32'h4000;
  endtask

  // Reference: the plain c/h/w loop nest with multiplied offsets.
  task automatic load_job(input int h, input int w, input int c, input bit bc);
    req_t e;
    cfg_h = DIM_W'(h); cfg_w = DIM_W'(w); cfg_c = DIM_W'(c); cfg_b_bcast = bc;
    for (int i = 0; i < 3; i++) begin q[i].delete(); hs_cnt[i] = 0; stall[i] = 1'b0; end
    done_cnt = 0;
    last_o_addr = 32'h0;
    for (int ci = 0; ci < c; ci++)
      for (int hi = 0; hi < h; hi++)
        for (int wi = 0; wi < w; wi += MB) begin
          int n;
          logic [31:0] off;
          n = (w - wi < MB) ? (w - wi) : MB;
          off = 32'(wi * PIX);
          e.len = 8'(n - 1);
          e.addr = cfg_a_base + 32'(ci) * cfg_in_surf + 32'(hi) * cfg_in_line + off;
          q[0].push_back(e);
          if (bc) begin
            e.addr = cfg_b_base + 32'(ci) * cfg_in_surf;
            e.len = 8'd0;
          end else begin
            e.addr = cfg_b_base + 32'(ci) * cfg_in_surf + 32'(hi) * cfg_in_line + off;
          end
          q[1].push_back(e);
          e.len = 8'(n - 1);
          e.addr = cfg_o_base + 32'(ci) * cfg_out_surf + 32'(hi) * cfg_out_line + off;
          q[2].push_back(e);
        end
    model_tri = q[2].size();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int max_cyc, output int l);
    int n = 0;
    while (!done && n < max_cyc) begin tick(); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", max_cyc);
      l = -1;
    end else begin
      l = cyc - start_cyc + 1;
    end
  endtask

  task automatic finish_job(input int exp_tri, input int exp_perf, input int l, input bit chk_lat);
    tick();
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_pulse_width", 64'(done), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("perf_cycles", 64'(perf_cycles), 64'(exp_perf));
    check("a_triples", 64'(hs_cnt[0]), 64'(exp_tri));
    check("b_triples", 64'(hs_cnt[1]), 64'(exp_tri));
    check("o_triples", 64'(hs_cnt[2]), 64'(exp_tri));
    check("model_leftover", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    if (chk_lat) check("done_latency", 64'(l), 64'(exp_perf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valids"}, 64'({a_req_valid, b_req_valid, o_req_valid}), 64'd0);
    check({tag, "_addrs"}, 64'(a_req_addr | b_req_addr | o_req_addr), 64'd0);
    check({tag, "_lens"}, 64'(a_req_len | b_req_len | o_req_len), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_perf"}, 64'(perf_cycles), 64'd0);
  endtask

  initial begin
    tbl[0] = '{5, 64, 4, 1'b0, 80, 81, 32'h0800_FC00};
    tbl[1] = '{1, 20, 1, 1'b0, 2, 3, 32'h0800_0400};
    tbl[2] = '{2, 16, 2, 1'b1, 4, 5, 32'h0800_4C00};
    tbl[3] = '{0, 8, 2, 1'b0, 0, 1, 32'h0};
    tbl[4] = '{3, 17, 2, 1'b0, 12, 13, 32'h0};
    tbl[5] = '{1, 1, 1, 1'b0, 1, 2, 32'h0800_0000};
    tbl[6] = '{2, 33, 1, 1'b1, 6, 7, 32'h0};
    tbl[7] = '{2, 0, 3, 1'b0, 0, 1, 32'h0};

    rst = 1'b1; start = 1'b0;
    cfg_h = '0; cfg_w = '0; cfg_c = '0; cfg_b_bcast = 1'b0;
    default_cfg();
    a_req_ready = 1'b1; b_req_ready = 1'b1; o_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin hs_cnt[i] = 0; stall[i] = 1'b0; end
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      load_job(tbl[i].h, tbl[i].w, tbl[i].c, tbl[i].bc);
      pulse_start();
      wait_done(300, lat);
      finish_job(tbl[i].n_tri, tbl[i].perf, lat, 1'b1);
      if (tbl[i].last_o != 32'h0) check("last_o_addr", 64'(last_o_addr), 64'(tbl[i].last_o));
    end

    // O stalls ten cycles on the first triple while A and B are ready.
    load_job(1, 32, 1, 1'b0);
    o_req_ready = 1'b0;
    pulse_start();
    repeat (10) tick();
    check("skew_a_dropped", 64'(a_req_valid), 64'd0);
    check("skew_b_dropped", 64'(b_req_valid), 64'd0);
    check("skew_o_valid", 64'(o_req_valid), 64'd1);
    check("skew_o_addr", 64'(o_req_addr), 64'h0800_0000);
    check("skew_a_single_hs", 64'(hs_cnt[0]), 64'd1);
    o_req_ready = 1'b1;
    wait_done(100, lat);
    finish_job(2, 13, lat, 1'b1);

    // Second start with different dims mid-job is ignored.
    load_job(4, 32, 1, 1'b0);
    pulse_start();
    tick(); tick();
    cfg_h = DIM_W'(1);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(100, lat);
    finish_job(8, 9, lat, 1'b1);

    // Start during the DONE cycle is ignored.
    load_job(1, 16, 1, 1'b0);
    pulse_start();
    wait_done(100, lat);
    start = 1'b1; tick(); start = 1'b0;
    check("done_start_busy", 64'(busy), 64'd0);
    check("done_start_perf", 64'(perf_cycles), 64'd2);
    check("done_start_count", 64'(done_cnt), 64'd1);

    // Reset after seven triples aborts the job without done.
    load_job(5, 64, 4, 1'b0);
    pulse_start();
    for (int n = 0; n < 100 && hs_cnt[2] < 7; n++) tick();
    check("pre_reset_triples", 64'(hs_cnt[2]), 64'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero("midreset");
    repeat (3) tick();
    check("midreset_no_done", 64'(done_cnt), 64'd0);
    load_job(5, 64, 4, 1'b0);
    pulse_start();
    wait_done(300, lat);
    finish_job(80, 81, lat, 1'b1);

    // Random jobs with random bases, strides and ready patterns.
    rand_rdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      cfg_a_base = $urandom; cfg_b_base = $urandom; cfg_o_base = $urandom;
      cfg_in_surf = $urandom; cfg_in_line = $urandom;
      cfg_out_surf = $urandom; cfg_out_line = $urandom;
      load_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
               1'($urandom_range(0, 1)));
      pulse_start();
      wait_done(3000, lat);
      finish_job(model_tri, lat, lat, 1'b0);
    end
    rand_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
